output_weight_update: RTL and testbench
=======================================

// Module: output_weight_update
// PURPOSE
// - Backward-pass counterpart of the output neuron: takes the latched prediction and 4-bit target,
//   forms error = predicted - target, and serially updates the 8 stored output weights.
// - Sits after the output neuron in the training loop. Holds the weight registers that drive the
//   neuron's w0..w7 inputs, so the neuron can run the next forward pass on the updated weights.
// PARAMETERS
// - N_IN      8   number of inputs/weights
// - X_WIDTH   10  activation width (unsigned)
// - W_WIDTH   8   weight width (unsigned, 1.7 fixed point)
// - LR_SHIFT  10  learning-rate right shift applied to (|err| * x)
// PORTS
// - clk_i        in   1               clock, rising edge
// - rst_i        in   1               reset, asynchronous, active-low
// - load_i       in   1               load w_init_i into the weight registers (IDLE only)
// - w_init_i     in   N_IN*W_WIDTH    initial weights; weight k in bits [k*W_WIDTH +: W_WIDTH]
// - start_i      in   1               begin one update (IDLE only)
// - predicted_i  in   23              neuron output for this sample
// - target_i     in   4               label for this sample
// - x_i          in   N_IN*X_WIDTH    activations; x_k in bits [k*X_WIDTH +: X_WIDTH]
// - busy_o       out  1               high in ERR and UPD
// - done_o       out  1               one-cycle pulse when an update completes
// - w_o          out  N_IN*W_WIDTH    current weights (registered), same packing as w_init_i
// BEHAVIOUR
// - Reset: state=IDLE; w_o=0; busy_o=0; done_o=0; index k=0; captured operands=0.
// - A reset mid-operation aborts the update. Weights clear to 0 and are not restored.
// - IDLE:
//   - If load_i=1, w_q <= w_init_i. Load has priority over start_i in the same cycle, and that
//     start_i is dropped.
//   - Else if start_i=1, capture predicted_i, target_i and x_i, then go to ERR.
//   - start_i and load_i are ignored in every state other than IDLE.
// - ERR (1 cycle):
//   - err = {1'b0,predicted_i} - {20'b0,target_i}, 24-bit signed.
//   - sgn = err[23]; mag = |err|, saturated to 16 bits (0xFFFF if |err| > 65535). k <= 0.
//   - Go to UPD.
// - UPD (N_IN cycles, one weight per cycle):
//   - delta = (mag * x_k) >> LR_SHIFT. The 26-bit product is taken before the shift.
//   - sgn=0 (prediction high): w_k <= max(w_k - delta, 0).
//   - sgn=1 (prediction low):  w_k <= min(w_k + delta, 2^W_WIDTH-1).
//   - Saturation is computed at full width; no wrap-around allowed.
//   - After k = N_IN-1 go to DONE, else k <= k+1.
//   - Zero error is not special-cased. delta=0, weights are unchanged, latency is the same.
// - DONE (1 cycle): done_o=1, busy_o=0, then go to IDLE.
//   - A start_i seen in DONE is ignored and must be re-presented in IDLE.
// - Latency: from the edge that samples start_i, done_o is high N_IN+2 cycles later.
//   - Default: start sampled at edge 0 -> done_o high between edges 10 and 11.
// - w_o changes only on load_i in IDLE or on the UPD write of weight k. It is stable in all
//   other cycles.
// CONFIGURATION
// - Macro WU_EPOCH_CNT_EN.
//   - Defined: adds output port epoch_cnt_o [15:0]. It counts completed updates (increments in
//     the DONE cycle), saturates at 0xFFFF, resets to 0 and is not cleared by load_i.
//   - Undefined: the port and counter do not exist. All other behaviour is identical.
// TESTING
// - Zero error. Load all w=0x40; start with predicted=5, target=5, all x=1023.
//   -> done_o pulses exactly 10 cycles after start; all w stay 0x40; busy_o high for 9 cycles.
// - Decrease with saturation. All w=0x40; predicted=1024, target=0, all x=1023.
//   -> delta=1023, every w=0x00 (no wrap).
// - Increase. All w=0x40; predicted=0, target=8; x0=512, other x=0.
//   -> delta=4, w0=0x44, w1..w7 stay 0x40.
// - Upper clamp. w3=0xFE; predicted=0, target=15, x3=1023.
//   -> delta=14, w3=0xFF.
// - Control. start_i re-pulsed while busy -> ignored, still exactly one done_o.
//   load_i+start_i in the same IDLE cycle -> load only, busy_o stays 0.
//   rst_i low during UPD -> w_o=0, busy_o=0, done_o=0 immediately.
// - With WU_EPOCH_CNT_EN: 3 back-to-back updates -> epoch_cnt_o=3.
//   Forced to 0xFFFF then one more update -> stays 0xFFFF.

Source files
------------

// File: rtl/output_weight_update.sv
// Backward-pass weight update for the output neuron: error = predicted - target, then one weight per cycle.
// Optional epoch counter port epoch_cnt_o is enabled with macro WU_EPOCH_CNT_EN.
module output_weight_update #(
  parameter int N_IN     = 8,
  parameter int X_WIDTH  = 10,
  parameter int W_WIDTH  = 8,
  parameter int LR_SHIFT = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [N_IN*W_WIDTH-1:0]   w_init_i,
  input  logic                      start_i,
  input  logic [22:0]               predicted_i,
  input  logic [3:0]                target_i,
  input  logic [N_IN*X_WIDTH-1:0]   x_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [N_IN*W_WIDTH-1:0]   w_o
`ifdef WU_EPOCH_CNT_EN
  ,
  output logic [15:0]               epoch_cnt_o
`endif
);

  localparam int K_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int P_WIDTH = 16 + X_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR  = 2'd1,
    S_UPD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state_q;
  logic [W_WIDTH-1:0]        w_q [N_IN];
  logic [K_WIDTH-1:0]        k_q;
  logic [22:0]               pred_q;
  logic [3:0]                tgt_q;
  logic [N_IN*X_WIDTH-1:0]   x_q;
  logic                      sgn_q;
  logic [15:0]               mag_q;
  logic                      busy_q;
  logic                      done_q;
`ifdef WU_EPOCH_CNT_EN
  logic [15:0]               epoch_q;
`endif

  logic [23:0]               err_s;
  logic [23:0]               abs_s;
  logic [15:0]               mag_d;
  logic [X_WIDTH-1:0]        x_k_s;
  logic [P_WIDTH-1:0]        prod_s;
  logic [P_WIDTH-1:0]        delta_s;
  logic [P_WIDTH-1:0]        w_ext_s;
  logic [P_WIDTH:0]          sum_s;
  logic [W_WIDTH-1:0]        w_upd_d;

  // Error magnitude (saturated to 16 bits) and per-weight saturating update.
  always_comb begin
    err_s   = {1'b0, pred_q} - {20'b0, tgt_q};
    abs_s   = err_s[23] ? (24'd0 - err_s) : err_s;
    mag_d   = (abs_s > 24'd65535) ? 16'hFFFF : abs_s[15:0];
    x_k_s   = x_q[int'(k_q)*X_WIDTH +: X_WIDTH];
    prod_s  = P_WIDTH'(mag_q) * P_WIDTH'(x_k_s);
    delta_s = prod_s >> LR_SHIFT;
    w_ext_s = P_WIDTH'(w_q[k_q]);
    sum_s   = {1'b0, w_ext_s} + {1'b0, delta_s};
    if (sgn_q) begin
      if (sum_s > (P_WIDTH+1)'({W_WIDTH{1'b1}})) begin
        w_upd_d = {W_WIDTH{1'b1}};
      end else begin
        w_upd_d = sum_s[W_WIDTH-1:0];
      end
    end else begin
      if (delta_s >= w_ext_s) begin
        w_upd_d = {W_WIDTH{1'b0}};
      end else begin
        w_upd_d = w_ext_s[W_WIDTH-1:0] - delta_s[W_WIDTH-1:0];
      end
    end
  end

  // Control FSM, operand capture, weight storage and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      for (int i = 0; i < N_IN; i++) w_q[i] <= {W_WIDTH{1'b0}};
      k_q     <= {K_WIDTH{1'b0}};
      pred_q  <= 23'd0;
      tgt_q   <= 4'd0;
      x_q     <= {(N_IN*X_WIDTH){1'b0}};
      sgn_q   <= 1'b0;
      mag_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WU_EPOCH_CNT_EN
      epoch_q <= 16'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_i) begin
            for (int i = 0; i < N_IN; i++) w_q[i] <= w_init_i[i*W_WIDTH +: W_WIDTH];
          end else if (start_i) begin
            pred_q  <= predicted_i;
            tgt_q   <= target_i;
            x_q     <= x_i;
            busy_q  <= 1'b1;
            state_q <= S_ERR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          sgn_q   <= err_s[23];
          mag_q   <= mag_d;
          k_q     <= {K_WIDTH{1'b0}};
          state_q <= S_UPD;
        end
        S_UPD: begin
          w_q[k_q] <= w_upd_d;
          if (k_q == K_WIDTH'(N_IN - 1)) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + K_WIDTH'(1);
          end
        end
        S_DONE: begin
          // done_o is registered, so it is visible on the cycle after DONE.
          done_q  <= 1'b1;
`ifdef WU_EPOCH_CNT_EN
          if (epoch_q != 16'hFFFF) epoch_q <= epoch_q + 16'd1;
`endif
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_wout
    assign w_o[g*W_WIDTH +: W_WIDTH] = w_q[g];
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
`ifdef WU_EPOCH_CNT_EN
  assign epoch_cnt_o = epoch_q;
`endif

endmodule

// File: tb/tb_output_weight_update.sv
// Directed bench for output_weight_update with a scoreboard of expected weight vectors.
// Define WU_EPOCH_CNT_EN to also exercise the epoch counter.
module tb_output_weight_update;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_i;
  logic [63:0] w_init_i;
  logic        start_i;
  logic [22:0] predicted_i;
  logic [3:0]  target_i;
  logic [79:0] x_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] w_o;
`ifdef WU_EPOCH_CNT_EN
  logic [15:0] epoch_cnt_o;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q [$];
  logic [7:0]  wm [8];

  always #5 clk_i = ~clk_i;

  output_weight_update dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_i),
    .w_init_i    (w_init_i),
    .start_i     (start_i),
    .predicted_i (predicted_i),
    .target_i    (target_i),
    .x_i         (x_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .w_o         (w_o)
`ifdef WU_EPOCH_CNT_EN
    ,
    .epoch_cnt_o (epoch_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] pack_wm();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = wm[k];
    return v;
  endfunction

  task automatic model_update(input logic [22:0] pred, input logic [3:0] tgt, input logic [79:0] x);
    longint err, mag, d, w;
    err = longint'(pred) - longint'(tgt);
    mag = (err < 0) ? -err : err;
    if (mag > 65535) mag = 65535;
    for (int k = 0; k < 8; k++) begin
      d = (mag * longint'(x[k*10 +: 10])) / 1024;
      w = longint'(wm[k]);
      if (err < 0) w = (w + d > 255) ? 255 : w + d;
      else         w = (w - d < 0) ? 0 : w - d;
      wm[k] = w[7:0];
    end
  endtask

  task automatic do_load(input logic [63:0] w);
    load_i   = 1'b1;
    w_init_i = w;
    step();
    load_i = 1'b0;
    for (int k = 0; k < 8; k++) wm[k] = w[k*8 +: 8];
  endtask

  task automatic do_update(input string tag, input logic [22:0] pred, input logic [3:0] tgt,
                           input logic [79:0] x, input bit repulse);
    int n;
    int busy_cnt;
    int extra_done;
    logic [63:0] exp_w;
    predicted_i = pred;
    target_i    = tgt;
    x_i         = x;
    start_i     = 1'b1;
    model_update(pred, tgt, x);
    exp_q.push_back(pack_wm());
    step();
    start_i     = 1'b0;
    // Scramble the live inputs so only the captured operands can produce the right result.
    predicted_i = 23'h7FFFFF;
    target_i    = 4'hF;
    x_i         = {80{1'b1}};
    n = 0;
    busy_cnt = 0;
    while (!done_o && n < 40) begin
      if (busy_o) busy_cnt++;
      start_i = (repulse && (n == 3 || n == 9)) ? 1'b1 : 1'b0;
      step();
      n++;
    end
    start_i = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd10);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd9);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    check({tag, "_weights"}, w_o, exp_w);
    step();
    check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
    if (repulse) begin
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
        if (done_o || busy_o) extra_done++;
        step();
      end
      check({tag, "_no_second_run"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    rst_i       = 1'b0;
    load_i      = 1'b0;
    w_init_i    = 64'd0;
    start_i     = 1'b0;
    predicted_i = 23'd0;
    target_i    = 4'd0;
    x_i         = 80'd0;
    for (int k = 0; k < 8; k++) wm[k] = 8'd0;
    step();
    step();
    check("reset_w", w_o, 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    rst_i = 1'b1;
    step();

    do_load({8{8'h40}});
    check("load_w", w_o, {8{8'h40}});

    do_update("zero_err", 23'd5, 4'd5, {8{10'd1023}}, 1'b0);

    do_load({8{8'h40}});
    do_update("dec_sat", 23'd1024, 4'd0, {8{10'd1023}}, 1'b0);

    do_load({8{8'h40}});
    do_update("inc", 23'd0, 4'd8, {70'd0, 10'd512}, 1'b0);

    do_load({{4{8'h40}}, 8'hFE, {3{8'h40}}});
    do_update("upper_clamp", 23'd0, 4'd15, {40'd0, 10'd1023, 30'd0}, 1'b0);

    do_load({8{8'h80}});
    do_update("mag_sat", 23'h7FFFFF, 4'd0, {8{10'd1}}, 1'b0);

    do_load({8{8'h40}});
    do_update("repulse", 23'd0, 4'd8, {8{10'd512}}, 1'b1);

    // Load and start together: only the load happens.
    load_i      = 1'b1;
    start_i     = 1'b1;
    w_init_i    = 64'h1122334455667788;
    predicted_i = 23'd0;
    target_i    = 4'd15;
    x_i         = {8{10'd1023}};
    step();
    load_i  = 1'b0;
    start_i = 1'b0;
    for (int k = 0; k < 8; k++) wm[k] = w_init_i[k*8 +: 8];
    check("ld_st_busy", 64'(busy_o), 64'd0);
    check("ld_st_w", w_o, 64'h1122334455667788);
    step();
    step();
    check("ld_st_busy_later", 64'(busy_o), 64'd0);
    check("ld_st_w_later", w_o, 64'h1122334455667788);

    for (int r = 0; r < 4; r++) begin
      do_load({$urandom, $urandom});
      do_update("random", 23'($urandom_range(0, 3000)), 4'($urandom), {16'($urandom), $urandom, $urandom}, 1'b0);
    end

    // Reset in the middle of UPD aborts and clears.
    do_load({8{8'h40}});
    predicted_i = 23'd1024;
    target_i    = 4'd0;
    x_i         = {8{10'd1023}};
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    step();
    check("mid_upd_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b0;
    #1;
    check("rst_mid_w", w_o, 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    step();
    rst_i = 1'b1;
    for (int k = 0; k < 8; k++) wm[k] = 8'd0;
    step();

`ifdef WU_EPOCH_CNT_EN
    check("epoch_reset", 64'(epoch_cnt_o), 64'd0);
    do_load({8{8'h20}});
    check("epoch_not_cleared_by_load", 64'(epoch_cnt_o), 64'd0);
    for (int r = 0; r < 3; r++) do_update("epoch_run", 23'd3, 4'd1, {8{10'd700}}, 1'b0);
    check("epoch_three", 64'(epoch_cnt_o), 64'd3);
    force dut.epoch_q = 16'hFFFF;
    step();
    release dut.epoch_q;
    do_update("epoch_sat_run", 23'd3, 4'd1, {8{10'd700}}, 1'b0);
    check("epoch_sat", 64'(epoch_cnt_o), 64'hFFFF);
`else
    do_update("post_reset", 23'd0, 4'd9, {8{10'd1000}}, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
